// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Multicycle MIPS control FSM. Sequences fetch, decode, ALU,
//               memory and PC-update steps and drives the datapath strobes.
//               Stalls in the memory-access states until memReady.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               memReady,
    output logic               pcWrite,
    output logic               pcWriteCond,
    output logic               iorD,
    output logic               memRead,
    output logic               memWrite,
    output logic               irWrite,
    output logic               memToReg,
    output logic [1:0]         pcSource,
    output logic [1:0]         aluOp,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic               regWrite,
    output logic               regDst,
    output logic               instrDone,
    output logic               illegalOp,
    output logic [STATE_W-1:0] state
);

    localparam logic [STATE_W-1:0] c_FETCH  = STATE_W'(0);
    localparam logic [STATE_W-1:0] c_DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] c_MEMADR = STATE_W'(2);
    localparam logic [STATE_W-1:0] c_MEMRD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] c_MEMWB  = STATE_W'(4);
    localparam logic [STATE_W-1:0] c_MEMWR  = STATE_W'(5);
    localparam logic [STATE_W-1:0] c_EXEC   = STATE_W'(6);
    localparam logic [STATE_W-1:0] c_ALUWB  = STATE_W'(7);
    localparam logic [STATE_W-1:0] c_BRANCH = STATE_W'(8);
    localparam logic [STATE_W-1:0] c_ADDIEX = STATE_W'(9);
    localparam logic [STATE_W-1:0] c_ADDIWB = STATE_W'(10);
    localparam logic [STATE_W-1:0] c_JUMP   = STATE_W'(11);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic               r_is_load;

    assign state = r_state;

    // Next-state selection; opcode is only consulted while in DECODE.
    always_comb begin
        w_next = c_FETCH;
        case (r_state)
            c_FETCH:  w_next = memReady ? c_DECODE : c_FETCH;
            c_DECODE: begin
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next = c_MEMADR;
                    c_OP_RTYPE:       w_next = c_EXEC;
                    c_OP_BEQ:         w_next = c_BRANCH;
                    c_OP_ADDI:        w_next = c_ADDIEX;
                    c_OP_J:           w_next = c_JUMP;
                    default:          w_next = c_FETCH;
                endcase
            end
            c_MEMADR: w_next = r_is_load ? c_MEMRD : c_MEMWR;
            c_MEMRD:  w_next = memReady ? c_MEMWB : c_MEMRD;
            c_MEMWB:  w_next = c_FETCH;
            c_MEMWR:  w_next = memReady ? c_FETCH : c_MEMWR;
            c_EXEC:   w_next = c_ALUWB;
            c_ALUWB:  w_next = c_FETCH;
            c_BRANCH: w_next = c_FETCH;
            c_ADDIEX: w_next = c_ADDIWB;
            c_ADDIWB: w_next = c_FETCH;
            c_JUMP:   w_next = c_FETCH;
            default:  w_next = c_FETCH;
        endcase
    end

    // Moore strobe decode; only the memory-completion strobes look at memReady.
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        pcSource    = 2'b00;
        aluOp       = 2'b00;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        regWrite    = 1'b0;
        regDst      = 1'b0;
        instrDone   = 1'b0;
        illegalOp   = 1'b0;
        case (r_state)
            c_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
            end
            c_DECODE: begin
                aluSrcB = 2'b11;
                case (opcode)
                    c_OP_LW, c_OP_SW, c_OP_RTYPE,
                    c_OP_BEQ, c_OP_ADDI, c_OP_J: illegalOp = 1'b0;
                    default:                     illegalOp = 1'b1;
                endcase
            end
            c_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            c_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            c_MEMWB: begin
                regWrite  = 1'b1;
                memToReg  = 1'b1;
                instrDone = 1'b1;
            end
            c_MEMWR: begin
                memWrite  = 1'b1;
                iorD      = 1'b1;
                instrDone = memReady;
            end
            c_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
            end
            c_ALUWB: begin
                regWrite  = 1'b1;
                regDst    = 1'b1;
                instrDone = 1'b1;
            end
            c_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
                instrDone   = 1'b1;
            end
            c_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            c_ADDIWB: begin
                regWrite  = 1'b1;
                instrDone = 1'b1;
            end
            c_JUMP: begin
                pcWrite   = 1'b1;
                pcSource  = 2'b10;
                instrDone = 1'b1;
            end
            default: begin
                pcWrite = 1'b0;
            end
        endcase
    end

    // State register plus the lw/sw flag captured while the opcode is valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_FETCH;
            r_is_load <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == c_DECODE) begin
                r_is_load <= (opcode == c_OP_LW);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Directed-vector bench for the multicycle MIPS control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] c_LW   = 6'b100011;
    localparam logic [5:0] c_SW   = 6'b101011;
    localparam logic [5:0] c_RT   = 6'b000000;
    localparam logic [5:0] c_BEQ  = 6'b000100;
    localparam logic [5:0] c_ADDI = 6'b001000;
    localparam logic [5:0] c_J    = 6'b000010;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       memReady;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg;
    logic [1:0] pcSource, aluOp, aluSrcB;
    logic       aluSrcA, regWrite, regDst, instrDone, illegalOp;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    mips_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memToReg(memToReg), .pcSource(pcSource), .aluOp(aluOp),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .regWrite(regWrite),
        .regDst(regDst), .instrDone(instrDone), .illegalOp(illegalOp),
        .state(state)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; memReady = 1'b0; opcode = c_RT;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        total++; if (state !== 4'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", state); end
        total++; if (memRead !== 1'b1) begin bad++; $display("FAIL rst_memRead: got %0b want 1", memRead); end
        total++; if (aluSrcB !== 2'b01) begin bad++; $display("FAIL rst_aluSrcB: got %0b want 01", aluSrcB); end
        total++; if (pcWrite !== 1'b0 || irWrite !== 1'b0) begin bad++; $display("FAIL rst_pcw_irw_idle: got %0b%0b want 00", pcWrite, irWrite); end
        total++; if (regWrite !== 1'b0 || memWrite !== 1'b0 || instrDone !== 1'b0 || illegalOp !== 1'b0)
            begin bad++; $display("FAIL rst_strobes: got rw=%0b mw=%0b done=%0b ill=%0b want 0", regWrite, memWrite, instrDone, illegalOp); end
        memReady = 1'b1;
        #1;
        total++; if (pcWrite !== 1'b1 || irWrite !== 1'b1) begin bad++; $display("FAIL rst_pcw_irw_ready: got %0b%0b want 11", pcWrite, irWrite); end
        memReady = 1'b0;
        tick();
        total++; if (state !== 4'd0) begin bad++; $display("FAIL rst_hold: got %0d want 0", state); end
    endtask

    task automatic test_reset_mid_instr();
        logic [3:0] es [3];
        es = '{4'd0, 4'd1, 4'd2};
        opcode = c_LW; memReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (state !== es[i]) begin bad++; $display("FAIL midrst_seq cyc%0d: got %0d want %0d", i, state, es[i]); end
            tick();
        end
        memReady = 1'b0; reset = 1'b1;
        @(negedge clk);
        total++; if (state !== 4'd3) begin bad++; $display("FAIL midrst_memrd: got %0d want 3", state); end
        tick();
        reset = 1'b0;
        total++; if (state !== 4'd0) begin bad++; $display("FAIL midrst_state: got %0d want 0", state); end
        total++; if (memRead !== 1'b1 || pcWrite !== 1'b0 || regWrite !== 1'b0 || irWrite !== 1'b0)
            begin bad++; $display("FAIL midrst_out: got mr=%0b pcw=%0b rw=%0b irw=%0b want 1000", memRead, pcWrite, regWrite, irWrite); end
    endtask

    task automatic test_rtype();
        logic [3:0] es [4];
        es = '{4'd0, 4'd1, 4'd6, 4'd7};
        opcode = c_RT; memReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i >= 2) opcode = c_BEQ;
            @(negedge clk);
            total++; if (state !== es[i]) begin bad++; $display("FAIL rt_seq cyc%0d: got %0d want %0d", i, state, es[i]); end
            total++; if (regWrite !== (i == 3) || regDst !== (i == 3))
                begin bad++; $display("FAIL rt_rw_rd cyc%0d: got %0b%0b want %0b%0b", i, regWrite, regDst, i == 3, i == 3); end
            total++; if (instrDone !== (i == 3)) begin bad++; $display("FAIL rt_done cyc%0d: got %0b want %0b", i, instrDone, i == 3); end
            total++; if (aluOp !== ((i == 2) ? 2'b10 : 2'b00)) begin bad++; $display("FAIL rt_aluOp cyc%0d: got %0b", i, aluOp); end
            tick();
        end
        total++; if (state !== 4'd0) begin bad++; $display("FAIL rt_end: got %0d want 0", state); end
    endtask

    task automatic test_lw_stall();
        logic [3:0] es [7];
        logic       rd [7];
        es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
        rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            memReady = rd[i];
            opcode   = (i < 2) ? c_LW : c_SW;
            @(negedge clk);
            total++; if (state !== es[i]) begin bad++; $display("FAIL lw_seq cyc%0d: got %0d want %0d", i, state, es[i]); end
            total++; if (regWrite !== (i == 6) || memToReg !== (i == 6) || regDst !== 1'b0)
                begin bad++; $display("FAIL lw_wb cyc%0d: got rw=%0b m2r=%0b rd=%0b", i, regWrite, memToReg, regDst); end
            total++; if (memRead !== (i == 0 || (i >= 3 && i <= 5)) || iorD !== (i >= 3 && i <= 5))
                begin bad++; $display("FAIL lw_mem cyc%0d: got mr=%0b iord=%0b", i, memRead, iorD); end
            total++; if (instrDone !== (i == 6) || memWrite !== 1'b0)
                begin bad++; $display("FAIL lw_done cyc%0d: got done=%0b mw=%0b", i, instrDone, memWrite); end
            tick();
        end
        total++; if (state !== 4'd0) begin bad++; $display("FAIL lw_end: got %0d want 0", state); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] es [10];
        logic [5:0] op [10];
        logic [1:0] exp_src;
        es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd11};
        op = '{c_SW, c_SW, c_LW, c_LW, c_BEQ, c_BEQ, c_LW, c_J, c_J, c_RT};
        memReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            opcode = op[i];
            exp_src = (es[i] == 4'd8) ? 2'b01 : ((es[i] == 4'd11) ? 2'b10 : 2'b00);
            @(negedge clk);
            total++; if (state !== es[i]) begin bad++; $display("FAIL b2b_seq cyc%0d: got %0d want %0d", i, state, es[i]); end
            total++; if (memWrite !== (es[i] == 4'd5)) begin bad++; $display("FAIL b2b_mw cyc%0d: got %0b", i, memWrite); end
            total++; if (pcWriteCond !== (es[i] == 4'd8) || aluOp !== ((es[i] == 4'd8) ? 2'b01 : 2'b00))
                begin bad++; $display("FAIL b2b_beq cyc%0d: got pwc=%0b aluOp=%0b", i, pcWriteCond, aluOp); end
            total++; if (pcWrite !== (es[i] == 4'd0 || es[i] == 4'd11) || pcSource !== exp_src)
                begin bad++; $display("FAIL b2b_pc cyc%0d: got pcw=%0b src=%0b want src=%0b", i, pcWrite, pcSource, exp_src); end
            total++; if (instrDone !== (i == 3 || i == 6 || i == 9))
                begin bad++; $display("FAIL b2b_done cyc%0d: got %0b", i, instrDone); end
            total++; if (regWrite === 1'b1 && memWrite === 1'b1) begin bad++; $display("FAIL b2b_rw_mw cyc%0d: got both 1 want exclusive", i); end
            tick();
        end
        total++; if (state !== 4'd0) begin bad++; $display("FAIL b2b_end: got %0d want 0", state); end
    endtask

    task automatic test_addi();
        logic [3:0] es [4];
        logic [1:0] sb [4];
        es = '{4'd0, 4'd1, 4'd9, 4'd10};
        sb = '{2'b01, 2'b11, 2'b10, 2'b00};
        opcode = c_ADDI; memReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (state !== es[i]) begin bad++; $display("FAIL addi_seq cyc%0d: got %0d want %0d", i, state, es[i]); end
            total++; if (aluSrcB !== sb[i] || aluSrcA !== (i == 2))
                begin bad++; $display("FAIL addi_alu cyc%0d: got srcA=%0b srcB=%0b want srcB=%0b", i, aluSrcA, aluSrcB, sb[i]); end
            total++; if (regWrite !== (i == 3) || regDst !== 1'b0 || memToReg !== 1'b0 || instrDone !== (i == 3))
                begin bad++; $display("FAIL addi_wb cyc%0d: got rw=%0b rd=%0b m2r=%0b done=%0b", i, regWrite, regDst, memToReg, instrDone); end
            tick();
        end
        total++; if (state !== 4'd0) begin bad++; $display("FAIL addi_end: got %0d want 0", state); end
    endtask

    task automatic test_fetch_stall();
        logic [3:0] es [6];
        logic       rd [6];
        es = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd11};
        rd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        opcode = c_J;
        for (int i = 0; i < 6; i++) begin
            memReady = rd[i];
            @(negedge clk);
            total++; if (state !== es[i]) begin bad++; $display("FAIL stall_seq cyc%0d: got %0d want %0d", i, state, es[i]); end
            total++; if (irWrite !== (i == 3)) begin bad++; $display("FAIL stall_irw cyc%0d: got %0b want %0b", i, irWrite, i == 3); end
            total++; if (pcWrite !== (i == 3 || i == 5)) begin bad++; $display("FAIL stall_pcw cyc%0d: got %0b", i, pcWrite); end
            total++; if (memRead !== (i < 4)) begin bad++; $display("FAIL stall_mr cyc%0d: got %0b want %0b", i, memRead, i < 4); end
            tick();
        end
        total++; if (state !== 4'd0) begin bad++; $display("FAIL stall_end: got %0d want 0", state); end
    endtask

    task automatic test_illegal();
        logic [3:0] es [2];
        es = '{4'd0, 4'd1};
        opcode = 6'b111111; memReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (state !== es[i]) begin bad++; $display("FAIL ill_seq cyc%0d: got %0d want %0d", i, state, es[i]); end
            total++; if (illegalOp !== (i == 1)) begin bad++; $display("FAIL ill_pulse cyc%0d: got %0b want %0b", i, illegalOp, i == 1); end
            total++; if (regWrite !== 1'b0 || memWrite !== 1'b0 || instrDone !== 1'b0)
                begin bad++; $display("FAIL ill_quiet cyc%0d: got rw=%0b mw=%0b done=%0b want 0", i, regWrite, memWrite, instrDone); end
            tick();
        end
        total++; if (state !== 4'd0 || illegalOp !== 1'b0)
            begin bad++; $display("FAIL ill_end: got state=%0d ill=%0b want 0/0", state, illegalOp); end
    endtask

    initial begin
        reset = 1'b1; memReady = 1'b0; opcode = c_RT;
        test_reset();
        test_reset_mid_instr();
        test_rtype();
        test_lw_stall();
        test_back_to_back();
        test_addi();
        test_fetch_stall();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
